// File: rtl/tdm_pkg.sv
// tdm_pkg: shared FSM state type, channel count and frame sizing helper for tdm_demux4
package tdm_pkg;
  typedef enum logic [1:0] {HUNT, RECV, PAR} tdm_state_t;
  localparam int NUM_CH = 4;
  function automatic int frame_bits(input int data_w);
    return NUM_CH * data_w;
  endfunction
endpackage

// File: rtl/tdm_demux4.sv
// tdm_demux4: recovers 4 TDM channels (sync slot + 4*DATA_W bits, ch0 first, MSB first) onto ch_out with frame_valid/sync_err/busy pulses; TDM_PARITY_EN adds an even parity bit and parity_err
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bit_en,
  input  logic                     sync_in,
  input  logic                     data_in,
  output logic [NUM_CH*DATA_W-1:0] ch_out,
  output logic                     frame_valid,
  output logic                     sync_err,
  output logic                     busy
`ifdef TDM_PARITY_EN
  ,
  output logic                     parity_err
`endif
);
  localparam int FB = frame_bits(DATA_W);
  localparam int CW = $clog2(FB);
`ifdef TDM_PARITY_EN
  localparam int SW = FB;
`else
  localparam int SW = FB - 1;
`endif
  tdm_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_shift;
  logic [FB-1:0] w_shift, w_src, w_map;
  logic          w_sync, w_bit, w_last;
  assign w_sync  = bit_en && sync_in;
  assign w_bit   = bit_en && !sync_in;
  assign w_shift = {r_shift[FB-2:0], data_in};
  assign w_last  = r_cnt == CW'(FB - 1);
`ifdef TDM_PARITY_EN
  assign w_src   = r_shift;
`else
  assign w_src   = w_shift;
`endif
  for (genvar k = 0; k < NUM_CH; k++) begin : g_map
    assign w_map[k*DATA_W +: DATA_W] = w_src[(NUM_CH-1-k)*DATA_W +: DATA_W];
  end
  assign busy = r_state != HUNT;
`ifdef TDM_PARITY_EN
  logic r_par;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_par      <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= w_bit && r_state == PAR && (r_par ^ data_in);
      r_par      <= w_sync ? 1'b0 : (w_bit && r_state == RECV) ? r_par ^ data_in : r_par;
    end
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= HUNT;
      r_cnt       <= '0;
      r_shift     <= '0;
      ch_out      <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (w_sync) begin
        sync_err <= r_state != HUNT;
        r_state  <= RECV;
        r_cnt    <= '0;
        r_shift  <= '0;
      end else if (w_bit && r_state == RECV) begin
        r_shift <= w_shift[SW-1:0];
        if (w_last) begin
`ifdef TDM_PARITY_EN
          r_state <= PAR;
`else
          ch_out      <= w_map;
          frame_valid <= 1'b1;
          r_state     <= HUNT;
`endif
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
`ifdef TDM_PARITY_EN
      else if (w_bit && r_state == PAR) begin
        r_state <= HUNT;
        if (!(r_par ^ data_in)) begin
          ch_out      <= w_map;
          frame_valid <= 1'b1;
        end
      end
`endif
    end
  end
endmodule
